// File: rtl/spi_mem_ctrl.sv
// SPI mode-0 memory master: issues one read (0x03) or write (0x02) frame per
// request, with parametrised address width, chip selects, data bytes and SCLK rate.
module spi_mem_ctrl #(
  parameter  int ADDR_BITS = 24,
  parameter  int NUM_CS    = 2,
  parameter  int MAX_BYTES = 4,
  parameter  int CLK_DIV   = 1,
  localparam int CS_BITS   = (NUM_CS > 1) ? $clog2(NUM_CS) : 1,
  localparam int NB_BITS   = $clog2(MAX_BYTES + 1),
  localparam int DW        = 8 * MAX_BYTES
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start_request,
  input  logic                         is_write,
  input  logic [CS_BITS+ADDR_BITS-1:0] target_address,
  input  logic [NB_BITS-1:0]           num_bytes,
  input  logic [DW-1:0]                write_value,
  output logic [DW-1:0]                fetched_data,
  output logic                         request_done,
  output logic                         busy,
  output logic                         err,
  output logic                         sclk,
  output logic                         mosi,
  output logic [NUM_CS-1:0]            cs_n,
  input  logic                         miso
);

  localparam int HDR   = 8 + ADDR_BITS;
  localparam int FB    = HDR + DW;
  localparam int BIT_W = $clog2(FB);
  localparam int IDX_W = $clog2(DW);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t              state_q;
  logic [DIV_W-1:0]    div_q;
  logic [BIT_W-1:0]    bit_q;
  logic [BIT_W-1:0]    last_q;
  logic [FB-1:0]       sr_q;
  logic                write_q;
  logic                pend_err_q;
  logic [DW-1:0]       fetched_q;
  logic                done_q;
  logic                busy_q;
  logic                err_q;
  logic                sclk_q;
  logic                mosi_q;
  logic [NUM_CS-1:0]   cs_n_q;

  logic [CS_BITS-1:0]  chip_d;
  logic                chip_ok_d;
  logic [NB_BITS-1:0]  nbytes_d;
  logic [DW-1:0]       wdata_d;
  logic [FB-1:0]       frame_d;
  logic [BIT_W-1:0]    last_d;
  logic [NUM_CS-1:0]   cs_sel_d;
  logic                half_end_d;
  logic                in_data_d;
  logic [IDX_W-1:0]    rx_idx_d;

  // Decode the request and build the left-aligned outgoing frame
  always_comb begin
    chip_d    = target_address[CS_BITS+ADDR_BITS-1 -: CS_BITS];
    chip_ok_d = ({1'b0, chip_d} < (CS_BITS + 1)'(NUM_CS));
    if (num_bytes > NB_BITS'(MAX_BYTES)) begin
      nbytes_d = NB_BITS'(MAX_BYTES);
    end else begin
      nbytes_d = num_bytes;
    end
    wdata_d = '0;
    for (int k = 0; k < MAX_BYTES; k++) begin
      wdata_d[DW-1-8*k -: 8] = write_value[8*k +: 8];
    end
    frame_d = {(is_write ? 8'h02 : 8'h03), target_address[ADDR_BITS-1:0],
               (is_write ? wdata_d : {DW{1'b0}})};
    last_d   = BIT_W'(HDR - 1) + BIT_W'({nbytes_d, 3'b000});
    cs_sel_d = NUM_CS'(1'b1) << chip_d;
    half_end_d = (div_q == DIV_W'(CLK_DIV - 1));
    in_data_d  = (bit_q >= BIT_W'(HDR));
    // Data bit d of the stream lands in byte d/8, bit 7-d%8: flip the low three bits
    rx_idx_d   = IDX_W'(bit_q - BIT_W'(HDR)) ^ IDX_W'(3'b111);
  end

  // Transaction sequencer with all pin and status outputs registered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      div_q      <= '0;
      bit_q      <= '0;
      last_q     <= '0;
      sr_q       <= '0;
      write_q    <= 1'b0;
      pend_err_q <= 1'b0;
      fetched_q  <= '0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      cs_n_q     <= '1;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_request) begin
            fetched_q <= '0;
            err_q     <= 1'b0;
            busy_q    <= 1'b1;
            write_q   <= is_write;
            last_q    <= last_d;
            div_q     <= '0;
            bit_q     <= '0;
            if (!chip_ok_d) begin
              state_q    <= DONE;
              pend_err_q <= 1'b1;
            end else if (nbytes_d == '0) begin
              state_q    <= DONE;
              pend_err_q <= 1'b0;
            end else begin
              state_q <= SHIFT;
              cs_n_q  <= ~cs_sel_d;
              mosi_q  <= frame_d[FB-1];
              sr_q    <= frame_d << 1;
            end
          end
        end
        SHIFT: begin
          if (half_end_d) begin
            div_q <= '0;
            if (!sclk_q) begin
              sclk_q <= 1'b1;
              if (!write_q && in_data_d) begin
                fetched_q[rx_idx_d] <= miso;
              end
            end else begin
              sclk_q <= 1'b0;
              if (bit_q == last_q) begin
                state_q <= DONE;
                cs_n_q  <= '1;
                mosi_q  <= 1'b0;
                done_q  <= 1'b1;
                busy_q  <= 1'b0;
                err_q   <= 1'b0;
              end else begin
                bit_q  <= bit_q + BIT_W'(1);
                mosi_q <= sr_q[FB-1];
                sr_q   <= sr_q << 1;
              end
            end
          end else begin
            div_q <= div_q + DIV_W'(1);
          end
        end
        DONE: begin
          // Requests rejected at the start edge report one cycle later
          if (!done_q) begin
            done_q <= 1'b1;
            busy_q <= 1'b0;
            err_q  <= pend_err_q;
          end else if (!start_request) begin
            done_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          cs_n_q  <= '1;
          sclk_q  <= 1'b0;
          mosi_q  <= 1'b0;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign fetched_data = fetched_q;
  assign request_done = done_q;
  assign busy         = busy_q;
  assign err          = err_q;
  assign sclk         = sclk_q;
  assign mosi         = mosi_q;
  assign cs_n         = cs_n_q;

endmodule

// File: tb/tb_spi_mem_ctrl.sv
// Self-checking bench for spi_mem_ctrl: two instances (default and a 3-chip,
// 16-bit-address, CLK_DIV=3 build) checked every cycle against a frame-level model.
module tb_spi_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_a, start_b, is_write, miso;
  logic [2:0]  num_bytes;
  logic [31:0] write_value;
  logic [24:0] ta_a;
  logic [17:0] ta_b;

  logic [31:0] fd_a, fd_b;
  logic        done_a, busy_a, err_a, sclk_a, mosi_a;
  logic        done_b, busy_b, err_b, sclk_b, mosi_b;
  logic [1:0]  cs_n_a;
  logic [2:0]  cs_n_b;

  logic        sel;
  logic [31:0] fd_m;
  logic        done_m, busy_m, err_m, sclk_m, mosi_m;
  logic [2:0]  cs_n_m;

  int checks = 0;
  int failures = 0;

  logic        cur_wr;
  logic [23:0] cur_addr;
  logic [31:0] cur_wv, cur_resp;
  int          cur_abits, cur_n;
  logic [95:0] mosi_cap;
  int          dt;

  always #5 clk = ~clk;

  spi_mem_ctrl dut_a (
    .clk(clk), .rst(rst), .start_request(start_a), .is_write(is_write),
    .target_address(ta_a), .num_bytes(num_bytes), .write_value(write_value),
    .fetched_data(fd_a), .request_done(done_a), .busy(busy_a), .err(err_a),
    .sclk(sclk_a), .mosi(mosi_a), .cs_n(cs_n_a), .miso(miso)
  );

  spi_mem_ctrl #(.ADDR_BITS(16), .NUM_CS(3), .MAX_BYTES(4), .CLK_DIV(3)) dut_b (
    .clk(clk), .rst(rst), .start_request(start_b), .is_write(is_write),
    .target_address(ta_b), .num_bytes(num_bytes), .write_value(write_value),
    .fetched_data(fd_b), .request_done(done_b), .busy(busy_b), .err(err_b),
    .sclk(sclk_b), .mosi(mosi_b), .cs_n(cs_n_b), .miso(miso)
  );

  assign fd_m   = sel ? fd_b   : fd_a;
  assign done_m = sel ? done_b : done_a;
  assign busy_m = sel ? busy_b : busy_a;
  assign err_m  = sel ? err_b  : err_a;
  assign sclk_m = sel ? sclk_b : sclk_a;
  assign mosi_m = sel ? mosi_b : mosi_a;
  assign cs_n_m = sel ? cs_n_b : {1'b1, cs_n_a};

  task automatic chk(input string name, input int t, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0d got=%0h expected=%0h", name, t, act, exp);
    end
  endtask

  // Bit i of the frame: command, address, then data bytes 0..n-1, MSB first
  function automatic logic frame_bit(input int i);
    logic [7:0] cmd;
    int d;
    cmd = cur_wr ? 8'h02 : 8'h03;
    if (i < 8) return cmd[7-i];
    if (i < 8 + cur_abits) return cur_addr[cur_abits-1-(i-8)];
    d = i - 8 - cur_abits;
    return cur_wv[8*(d/8) + 7 - (d%8)];
  endfunction

  function automatic logic resp_bit(input int i);
    int d;
    d = i - 8 - cur_abits;
    if (d >= 0 && d < 8 * cur_n) return cur_resp[8*(d/8) + 7 - (d%8)];
    else return 1'($urandom_range(0, 1));
  endfunction

  // One full handshake on instance s, every cycle compared to the model
  task automatic run_txn(input logic s, input logic wr, input logic [1:0] chip,
                         input logic [23:0] addr, input int nb, input logic [31:0] wv,
                         input logic [31:0] resp, input int hold, output int done_t);
    int div, ncs, n, nbits, tt, i, tn;
    logic bad, fast, b;
    logic [2:0]  exp_cs;
    logic [31:0] exp_fd;
    sel = s;
    div = s ? 3 : 1;
    ncs = s ? 3 : 2;
    cur_abits = s ? 16 : 24;
    n = (nb > 4) ? 4 : nb;
    bad = (int'(chip) >= ncs);
    fast = bad || (n == 0);
    nbits = 8 + cur_abits + 8 * n;
    tt = fast ? 1 : 2 * div * nbits;
    exp_fd = '0;
    if (!wr && !bad) for (int k = 0; k < n; k++) exp_fd[8*k +: 8] = resp[8*k +: 8];
    exp_cs = 3'b111;
    if (!fast) exp_cs[chip] = 1'b0;
    cur_wr = wr; cur_addr = addr; cur_wv = wv; cur_resp = resp; cur_n = n;
    is_write = wr;
    num_bytes = 3'(nb);
    write_value = wv;
    ta_a = {chip[0], addr};
    ta_b = {chip, addr[15:0]};
    if (s) start_b = 1'b1; else start_a = 1'b1;
    done_t = -1;
    mosi_cap = '0;
    for (int t = 0; t <= tt + hold; t++) begin
      @(negedge clk);
      if (done_m === 1'b1 && done_t < 0) done_t = t;
      if (t < tt) begin
        chk("busy", t, 64'(busy_m), 64'd1);
        chk("done_early", t, 64'(done_m), 64'd0);
        if (t == 0) chk("fetched_clear", t, 64'(fd_m), 64'd0);
        if (fast) begin
          chk("cs_n_idle", t, 64'(cs_n_m), 64'h7);
          chk("sclk_idle", t, 64'(sclk_m), 64'd0);
        end else begin
          i = t / (2 * div);
          chk("cs_n", t, 64'(cs_n_m), 64'(exp_cs));
          chk("sclk", t, 64'(sclk_m), 64'((t % (2 * div)) >= div));
          if (i < 8 + cur_abits || wr) chk("mosi", t, 64'(mosi_m), 64'(frame_bit(i)));
          if (t % (2 * div) == div) mosi_cap = {mosi_cap[94:0], mosi_m};
        end
      end else begin
        chk("done", t, 64'(done_m), 64'd1);
        chk("busy_end", t, 64'(busy_m), 64'd0);
        chk("err", t, 64'(err_m), 64'(bad));
        chk("cs_n_end", t, 64'(cs_n_m), 64'h7);
        chk("sclk_end", t, 64'(sclk_m), 64'd0);
        chk("mosi_end", t, 64'(mosi_m), 64'd0);
        chk("fetched", t, 64'(fd_m), 64'(exp_fd));
      end
      // Correct miso only in the cycle ending at a rising SCLK edge
      tn = t + 1;
      b = resp_bit(tn / (2 * div));
      miso = (tn % (2 * div) == div) ? b : ~b;
    end
    if (s) start_b = 1'b0; else start_a = 1'b0;
    @(negedge clk);
    chk("done_drop", tt + hold + 1, 64'(done_m), 64'd0);
    chk("busy_idle", tt + hold + 1, 64'(busy_m), 64'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog t=%0t got=timeout expected=finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0; is_write = 1'b0; miso = 1'b0;
    num_bytes = 3'd0; write_value = 32'd0; ta_a = '0; ta_b = '0; sel = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cs_n_a", 0, 64'(cs_n_a), 64'h3);
    chk("rst_cs_n_b", 0, 64'(cs_n_b), 64'h7);
    chk("rst_sclk", 0, 64'(sclk_a), 64'd0);
    chk("rst_mosi", 0, 64'(mosi_a), 64'd0);
    chk("rst_done", 0, 64'(done_a), 64'd0);
    chk("rst_busy", 0, 64'(busy_a), 64'd0);
    chk("rst_err", 0, 64'(err_a), 64'd0);
    chk("rst_fetched", 0, 64'(fd_a), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Read chip 0, address 0x001000, four bytes returning 13 05 00 00
    run_txn(1'b0, 1'b0, 2'd0, 24'h001000, 4, 32'h0, 32'h00000513, 0, dt);
    chk("t1_done_at", 0, 64'(dt), 64'd128);
    chk("t1_fetched", 0, 64'(fd_a), 64'h00000513);
    chk("t1_header", 0, 64'(mosi_cap[63:32]), 64'h03001000);

    // Write chip 1, two bytes of 0xDEADBEEF
    run_txn(1'b0, 1'b1, 2'd1, 24'h000020, 2, 32'hDEADBEEF, 32'h0, 1, dt);
    chk("t2_done_at", 0, 64'(dt), 64'd96);
    chk("t2_frame", 0, 64'(mosi_cap[47:0]), 64'h02000020EFBE);
    chk("t2_fetched", 0, 64'(fd_a), 64'd0);

    // Slow instance: one-byte read
    run_txn(1'b1, 1'b0, 2'd0, 24'h001234, 1, 32'h0, 32'h000000A5, 0, dt);
    chk("t3_done_at", 0, 64'(dt), 64'd192);
    chk("t3_fetched", 0, 64'(fd_b), 64'h000000A5);
    chk("t3_header", 0, 64'(mosi_cap[31:8]), 64'h031234);

    // Nonexistent chip, then a good chip
    run_txn(1'b1, 1'b0, 2'd3, 24'h000010, 2, 32'h0, 32'h0, 2, dt);
    chk("t4_done_at", 0, 64'(dt), 64'd1);
    run_txn(1'b1, 1'b0, 2'd0, 24'h000010, 2, 32'h0, 32'h00007E81, 0, dt);

    // Clamp and zero-byte
    run_txn(1'b0, 1'b1, 2'd1, 24'h00ABCD, 7, 32'h11223344, 32'h0, 0, dt);
    chk("t5_done_at", 0, 64'(dt), 64'd128);
    chk("t5_data", 0, 64'(mosi_cap[31:0]), 64'h44332211);
    run_txn(1'b0, 1'b0, 2'd0, 24'h000000, 0, 32'h0, 32'h0, 1, dt);
    chk("t5_zero_done_at", 0, 64'(dt), 64'd1);

    // Asynchronous reset at bit 20 of a chip-1 read
    sel = 1'b0; is_write = 1'b0; num_bytes = 3'd4; ta_a = {1'b1, 24'h00ABCD};
    start_a = 1'b1;
    @(posedge clk);
    repeat (40) @(posedge clk);
    #2;
    chk("rst_mid_cs", 0, 64'(cs_n_a), 64'h1);
    chk("rst_mid_busy", 0, 64'(busy_a), 64'd1);
    rst = 1'b1;
    #1;
    chk("rst_async_cs", 0, 64'(cs_n_a), 64'h3);
    chk("rst_async_sclk", 0, 64'(sclk_a), 64'd0);
    chk("rst_async_busy", 0, 64'(busy_a), 64'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rst_no_done", k, 64'(done_a), 64'd0);
    end
    start_a = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_after_done", 0, 64'(done_a), 64'd0);
    run_txn(1'b0, 1'b0, 2'd1, 24'h00ABCD, 3, 32'h0, 32'h00C0FFEE, 5, dt);
    chk("t6_done_at", 0, 64'(dt), 64'd112);

    // Randomized traffic on both instances
    for (int r = 0; r < 24; r++) begin
      logic s;
      s = (r % 4 == 3);
      run_txn(s, 1'($urandom_range(0, 1)),
              s ? 2'($urandom_range(0, 3)) : 2'($urandom_range(0, 1)),
              24'($urandom), int'($urandom_range(0, 7)), $urandom, $urandom,
              int'($urandom_range(0, 2)), dt);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
